// File: rtl/flit_bus_collector_pkg.sv
// Shared sizing defaults, output-stage state type and log helper for the flit bus collector.
package flit_bus_collector_pkg;

    localparam int unsigned NNODES_DEF     = 4;
    localparam int unsigned FLIT_WIDTH_DEF = 36;
    localparam int unsigned NH_WIDTH_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF    = 1024;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    // floor(log2(x)); clogb2(NNODES-1)+1 is the bit width that holds any node index
    function automatic int unsigned clogb2(input int unsigned x);
        int unsigned v;
        int unsigned r;
        v = x;
        r = 0;
        while (v > 1) begin
            v = v >> 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/flit_bus_collector_if.sv
// Node egress ports plus shared broadcast bus; master is the collector, slave the Node side.
interface flit_bus_collector_if
    import flit_bus_collector_pkg::*;
#(
    parameter int unsigned NNODES     = NNODES_DEF,
    parameter int unsigned FLIT_WIDTH = FLIT_WIDTH_DEF,
    parameter int unsigned NH_WIDTH   = NH_WIDTH_DEF
);

    logic [NNODES-1:0]            node_flit_valid;
    logic [NNODES*FLIT_WIDTH-1:0] node_flit;
    logic [NNODES*NH_WIDTH-1:0]   node_nexthop;
    logic [NNODES-1:0]            node_dequeue;
    logic                         bus_flit_valid;
    logic [FLIT_WIDTH-1:0]        bus_flit;
    logic [NH_WIDTH-1:0]          bus_nexthop;
    logic                         bus_flit_ack;

    modport master (
        input  node_flit_valid, node_flit, node_nexthop, bus_flit_ack,
        output node_dequeue, bus_flit_valid, bus_flit, bus_nexthop
    );

    modport slave (
        output node_flit_valid, node_flit, node_nexthop, bus_flit_ack,
        input  node_dequeue, bus_flit_valid, bus_flit, bus_nexthop
    );

endinterface

// File: rtl/flit_bus_collector_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping modulo NNODES.
module rr_arbiter
    import flit_bus_collector_pkg::*;
#(
    parameter int unsigned NNODES = NNODES_DEF,
    parameter int unsigned PW     = clogb2(NNODES - 1) + 1
) (
    input  logic [NNODES-1:0] req_i,
    input  logic [PW-1:0]     ptr_i,
    input  logic              en_i,
    output logic [NNODES-1:0] grant_o,
    output logic [PW-1:0]     idx_o
);

    logic found;

    always_comb begin
        found   = 1'b0;
        idx_o   = '0;
        grant_o = '0;
        for (int unsigned i = 0; i < NNODES; i++) begin
            logic [PW-1:0] pos;
            pos = PW'((32'(ptr_i) + i) % NNODES);
            if (!found && req_i[pos]) begin
                found = 1'b1;
                idx_o = pos;
            end
        end
        if (en_i && found) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/flit_bus_collector.sv
// Round-robin collector from Node egress ports into a one-entry broadcast stage on the shared flit bus.
module flit_bus_collector
    import flit_bus_collector_pkg::*;
#(
    parameter int unsigned NNODES     = NNODES_DEF,
    parameter int unsigned FLIT_WIDTH = FLIT_WIDTH_DEF,
    parameter int unsigned NH_WIDTH   = NH_WIDTH_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    flit_bus_collector_if.master  bus,
    output logic                  error,
    output logic                  is_quiescent,
    output logic [15:0]           flit_count
);

    localparam int unsigned PW = clogb2(NNODES - 1) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    stage_e                stage_q;
    logic [FLIT_WIDTH-1:0] flit_q;
    logic [NH_WIDTH-1:0]   nh_q;
    logic [PW-1:0]         ptr_q;
    logic [TW-1:0]         tcnt_q;
    logic                  error_q;
    logic [15:0]           count_q;

    logic                  ack_full;
    logic                  grant_ok;
    logic [NNODES-1:0]     grant;
    logic [PW-1:0]         win_idx;
    logic [FLIT_WIDTH-1:0] win_flit;
    logic [NH_WIDTH-1:0]   win_nh;

    assign ack_full = (stage_q == ST_FULL) && bus.bus_flit_ack;
    // Reset gates the grant so no dequeue pulse escapes while reset is held.
    assign grant_ok = !reset && enable && (|bus.node_flit_valid) &&
                      ((stage_q == ST_EMPTY) || bus.bus_flit_ack);

    rr_arbiter #(
        .NNODES (NNODES),
        .PW     (PW)
    ) u_arb (
        .req_i   (bus.node_flit_valid),
        .ptr_i   (ptr_q),
        .en_i    (grant_ok),
        .grant_o (grant),
        .idx_o   (win_idx)
    );

    always_comb begin
        win_flit = '0;
        win_nh   = '0;
        for (int unsigned i = 0; i < NNODES; i++) begin
            if (win_idx == PW'(i)) begin
                win_flit = bus.node_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
                win_nh   = bus.node_nexthop[i*NH_WIDTH +: NH_WIDTH];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_q <= ST_EMPTY;
            flit_q  <= '0;
            nh_q    <= '0;
            ptr_q   <= '0;
            tcnt_q  <= '0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (grant_ok) begin
                stage_q <= ST_FULL;
                flit_q  <= win_flit;
                nh_q    <= win_nh;
                ptr_q   <= (win_idx == PW'(NNODES - 1)) ? '0 : win_idx + 1'b1;
                tcnt_q  <= '0;
            end else if (ack_full) begin
                stage_q <= ST_EMPTY;
                tcnt_q  <= '0;
            end else if ((stage_q == ST_FULL) && (tcnt_q != TW'(TIMEOUT - 1))) begin
                tcnt_q <= tcnt_q + 1'b1;
                if (tcnt_q == TW'(TIMEOUT - 2)) begin
                    error_q <= 1'b1;
                end
            end
            if (ack_full) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign bus.node_dequeue   = grant;
    assign bus.bus_flit_valid = (stage_q == ST_FULL);
    assign bus.bus_flit       = flit_q;
    assign bus.bus_nexthop    = nh_q;
    assign error              = error_q;
    assign flit_count         = count_q;
    assign is_quiescent       = (stage_q == ST_EMPTY) && !(|bus.node_flit_valid);

endmodule
